// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box, round constants, and
// optionally the inverse S-box (enabled by the AES_S_BOX_INV_EN macro).
// Table rows are 16 bytes; element 0 is the leftmost byte of row 0.
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   // FIPS-197 forward substitution table, indexed by {row=b[7:4], col=b[3:0]}
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Key-expansion round constants (first byte of Rcon[i], i = 1..10)
   localparam byte_t RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward byte substitution, usable anywhere without instantiating a block
   function automatic byte_t sub_byte(input byte_t b);
      return SBOX[b];
   endfunction

`ifdef AES_S_BOX_INV_EN
   // FIPS-197 inverse substitution table, same indexing as SBOX
   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Inverse byte substitution
   function automatic byte_t inv_sub_byte(input byte_t b);
      return INV_SBOX[b];
   endfunction
`endif

endpackage

// File: rtl/aes_s_box.sv
// AES SubBytes for a single byte: a zero-latency combinational output for
// the key-expansion path and an optional one-cycle registered output with a
// valid flag (REG_OUT). Defining AES_S_BOX_INV_EN adds the inv port, which
// selects the inverse table for both outputs.
module aes_s_box
   import aes_pkg::*;
#(
   parameter int REG_OUT = 1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in,
   input  logic       in_valid,
`ifdef AES_S_BOX_INV_EN
   input  logic       inv,
`endif
   output logic [7:0] out,
   output logic [7:0] out_q,
   output logic       out_valid
);

   byte_t sub_val;

   // Table lookup; independent of clk and rst so it is valid during reset
   always_comb begin
      sub_val = sub_byte(in);
`ifdef AES_S_BOX_INV_EN
      if (inv) begin
         sub_val = inv_sub_byte(in);
      end
`endif
   end

   assign out = sub_val;

   generate
      if (REG_OUT != 0) begin : g_reg
         byte_t q_r;
         logic  valid_r;

         // Capture stage: reset beats in_valid, data holds when no byte arrives
         always_ff @(posedge clk) begin
            if (rst) begin
               q_r     <= 8'h00;
               valid_r <= 1'b0;
            end else if (in_valid) begin
               q_r     <= sub_val;
               valid_r <= 1'b1;
            end else begin
               valid_r <= 1'b0;
            end
         end

         assign out_q     = q_r;
         assign out_valid = valid_r;
      end else begin : g_no_reg
         assign out_q     = 8'h00;
         assign out_valid = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_aes_s_box.sv
// Self-checking bench for aes_s_box. Expected values come from hand-computed
// FIPS-197 vectors and from an independent GF(2^8) inverse + affine model.
// Define AES_S_BOX_INV_EN to also exercise the inverse table.
module tb_aes_s_box;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       inValid;
   logic       invSel;
   logic [7:0] dout;
   logic [7:0] doutQ;
   logic       doutValid;

   logic [31:0] wordIn;
   logic [31:0] wordOut;
   logic [31:0] wordQ;
   logic [3:0]  wordValid;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] modelTab [0:255];

   always #5 clk = ~clk;

   aes_s_box dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (inValid),
`ifdef AES_S_BOX_INV_EN
      .inv       (invSel),
`endif
      .out       (dout),
      .out_q     (doutQ),
      .out_valid (doutValid)
   );

   // Four lookups side by side, as in the key-expansion SubWord step
   for (genvar k = 0; k < 4; k++) begin : g_word
      aes_s_box u_word (
         .clk       (clk),
         .rst       (rst),
         .in        (wordIn[8*k +: 8]),
         .in_valid  (1'b0),
`ifdef AES_S_BOX_INV_EN
         .inv       (1'b0),
`endif
         .out       (wordOut[8*k +: 8]),
         .out_q     (wordQ[8*k +: 8]),
         .out_valid (wordValid[k])
      );
   end

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] modelSbox(input logic [7:0] b);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (b != 8'h00 && gfMul(b, 8'(y)) == 8'h01) inv = 8'(y);
      end
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [7:0] b, input logic v, input logic iv);
      rst     = r;
      din     = b;
      inValid = v;
      invSel  = iv;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] spotIn  [6] = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hc9, 8'hff};
   logic [7:0] spotExp [6] = '{8'h63, 8'h7c, 8'hca, 8'hed, 8'hdd, 8'h16};

   initial begin
      for (int i = 0; i < 256; i++) modelTab[i] = modelSbox(8'(i));

      wordIn = 32'h0;
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
      stepClock();
      stepClock();
      checkOutput("reset_out_q", {24'h0, doutQ}, 32'h00);
      checkOutput("reset_out_valid", {31'h0, doutValid}, 32'h0);
      checkOutput("reset_comb_00", {24'h0, dout}, 32'h63);

      // Input presented during reset: comb path live, register held clear
      applyStimulus(1'b1, 8'h53, 1'b1, 1'b0);
      checkOutput("rst_comb_53", {24'h0, dout}, 32'hed);
      stepClock();
      checkOutput("rst_hold_q", {24'h0, doutQ}, 32'h00);
      checkOutput("rst_hold_valid", {31'h0, doutValid}, 32'h0);
      applyStimulus(1'b0, 8'h53, 1'b1, 1'b0);
      stepClock();
      checkOutput("release_q", {24'h0, doutQ}, 32'hed);
      checkOutput("release_valid", {31'h0, doutValid}, 32'h1);

      // Back-to-back stream, then drop in_valid
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      stepClock();
      checkOutput("b2b_q0", {24'h0, doutQ}, 32'h63);
      checkOutput("b2b_v0", {31'h0, doutValid}, 32'h1);
      applyStimulus(1'b0, 8'h01, 1'b1, 1'b0);
      stepClock();
      checkOutput("b2b_q1", {24'h0, doutQ}, 32'h7c);
      checkOutput("b2b_v1", {31'h0, doutValid}, 32'h1);
      applyStimulus(1'b0, 8'hff, 1'b1, 1'b0);
      stepClock();
      checkOutput("b2b_q2", {24'h0, doutQ}, 32'h16);
      checkOutput("b2b_v2", {31'h0, doutValid}, 32'h1);
      applyStimulus(1'b0, 8'h10, 1'b0, 1'b0);
      checkOutput("idle_comb_10", {24'h0, dout}, 32'hca);
      stepClock();
      checkOutput("idle_valid", {31'h0, doutValid}, 32'h0);
      checkOutput("idle_hold_q", {24'h0, doutQ}, 32'h16);
      applyStimulus(1'b0, 8'hc9, 1'b0, 1'b0);
      stepClock();
      checkOutput("idle_hold_q2", {24'h0, doutQ}, 32'h16);

      // Reset arriving mid-stream drops the in-flight byte
      applyStimulus(1'b0, 8'h10, 1'b1, 1'b0);
      stepClock();
      checkOutput("mid_q_ca", {24'h0, doutQ}, 32'hca);
      applyStimulus(1'b1, 8'hc9, 1'b1, 1'b0);
      stepClock();
      checkOutput("mid_rst_q", {24'h0, doutQ}, 32'h00);
      checkOutput("mid_rst_valid", {31'h0, doutValid}, 32'h0);
      applyStimulus(1'b0, 8'h53, 1'b0, 1'b0);
      stepClock();
      checkOutput("post_rst_q", {24'h0, doutQ}, 32'h00);
      checkOutput("post_rst_valid", {31'h0, doutValid}, 32'h0);

      // Hand-computed spot checks on the combinational path
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, spotIn[i], 1'b0, 1'b0);
         checkOutput($sformatf("spot_%02h", spotIn[i]), {24'h0, dout}, {24'h0, spotExp[i]});
      end

      // Full forward sweep against the GF(2^8) model
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b0, 8'(i), 1'b0, 1'b0);
         checkOutput($sformatf("sweep_%02h", i), {24'h0, dout}, {24'h0, modelTab[i]});
      end

      // SubWord(RotWord(09cf4f3c)) from the FIPS-197 key expansion example
      wordIn = {32'h09cf4f3c} << 8 | (32'h09cf4f3c >> 24);
      #1;
      checkOutput("subword", wordOut, 32'h8a84eb01);
      checkOutput("subword_valid", {28'h0, wordValid}, 32'h0);

`ifdef AES_S_BOX_INV_EN
      begin
         logic [7:0] invIn  [5] = '{8'h63, 8'hed, 8'h16, 8'h00, 8'h7c};
         logic [7:0] invExp [5] = '{8'h00, 8'h53, 8'hff, 8'h52, 8'h01};
         for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, invIn[i], 1'b0, 1'b1);
            checkOutput($sformatf("inv_%02h", invIn[i]), {24'h0, dout}, {24'h0, invExp[i]});
         end
         applyStimulus(1'b0, 8'hed, 1'b1, 1'b1);
         stepClock();
         checkOutput("inv_reg_q", {24'h0, doutQ}, 32'h53);
         checkOutput("inv_reg_valid", {31'h0, doutValid}, 32'h1);
         for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, modelTab[i], 1'b0, 1'b1);
            checkOutput($sformatf("roundtrip_%02h", i), {24'h0, dout}, i);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
